// File: rtl/z_match_monitor.sv
// Match statistics for the sequence detector's z output: BCD match counter with
// sticky overflow, current/longest run of z-high cycles, and three 7-segment digits.
module z_match_monitor (
    input  logic       clk,
    input  logic       reset,
    input  logic       z,
    input  logic       clr,
    output logic       match_pulse,
    output logic [7:0] bcd_count,
    output logic       ovf,
    output logic [3:0] run_len,
    output logic [3:0] max_run,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2
);

    logic       z_d_reg;
    logic       match_pulse_reg;
    logic [7:0] bcd_reg, bcd_next;
    logic       ovf_reg, ovf_next;
    logic [3:0] run_reg, run_next;
    logic [3:0] max_reg, max_next;
    logic       rise;

    // Active-low {g,f,e,d,c,b,a}; BCD digits blank on codes 10-15.
    function automatic logic [6:0] seg7(input logic [3:0] v, input logic bcd_only);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        if (bcd_only && (v > 4'd9)) begin
            s = 7'b1111111;
        end
        return s;
    endfunction

    assign rise = z & ~z_d_reg;

    always_comb begin
        bcd_next = bcd_reg;
        ovf_next = ovf_reg;
        if (rise) begin
            if (bcd_reg[3:0] == 4'd9) begin
                bcd_next[3:0] = 4'd0;
                if (bcd_reg[7:4] == 4'd9) begin
                    bcd_next[7:4] = 4'd0;
                    ovf_next      = 1'b1;
                end else begin
                    bcd_next[7:4] = bcd_reg[7:4] + 4'd1;
                end
            end else begin
                bcd_next[3:0] = bcd_reg[3:0] + 4'd1;
            end
        end
    end

    always_comb begin
        run_next = 4'd0;
        if (z) begin
            run_next = (run_reg == 4'hF) ? 4'hF : run_reg + 4'd1;
        end
        max_next = (z && (run_next > max_reg)) ? run_next : max_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            z_d_reg         <= 1'b0;
            match_pulse_reg <= 1'b0;
            bcd_reg         <= 8'h00;
            ovf_reg         <= 1'b0;
            run_reg         <= 4'd0;
            max_reg         <= 4'd0;
        end else if (clr) begin
            // z_d still tracks z so a level held through the clear is not a new match.
            z_d_reg         <= z;
            match_pulse_reg <= 1'b0;
            bcd_reg         <= 8'h00;
            ovf_reg         <= 1'b0;
            run_reg         <= 4'd0;
            max_reg         <= 4'd0;
        end else begin
            z_d_reg         <= z;
            match_pulse_reg <= rise;
            bcd_reg         <= bcd_next;
            ovf_reg         <= ovf_next;
            run_reg         <= run_next;
            max_reg         <= max_next;
        end
    end

    logic [6:0] digit_seg [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bcd_digit
            assign digit_seg[gi] = seg7(bcd_reg[gi*4 +: 4], 1'b1);
        end
    endgenerate

    assign match_pulse = match_pulse_reg;
    assign bcd_count   = bcd_reg;
    assign ovf         = ovf_reg;
    assign run_len     = run_reg;
    assign max_run     = max_reg;
    assign hex0        = digit_seg[0];
    assign hex1        = digit_seg[1];
    assign hex2        = seg7(max_reg, 1'b0);

endmodule

// File: tb/tb_z_match_monitor.sv
// Scoreboard bench for z_match_monitor: directed steps push hand-computed
// expectations; a monitor pops and compares one entry after every clock edge.
module tb_z_match_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       z = 1'b0;
    logic       clr = 1'b0;
    logic       match_pulse;
    logic [7:0] bcd_count;
    logic       ovf;
    logic [3:0] run_len;
    logic [3:0] max_run;
    logic [6:0] hex0, hex1, hex2;

    typedef struct {
        logic       mp;
        logic [7:0] bcd;
        logic       ov;
        logic [3:0] rl;
        logic [3:0] mr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_txn    = 0;
    logic [6:0] seg_tbl [16];

    z_match_monitor dut (
        .clk        (clk),
        .reset      (reset),
        .z          (z),
        .clr        (clr),
        .match_pulse(match_pulse),
        .bcd_count  (bcd_count),
        .ovf        (ovf),
        .run_len    (run_len),
        .max_run    (max_run),
        .hex0       (hex0),
        .hex1       (hex1),
        .hex2       (hex2)
    );

    always #5 clk = ~clk;

    initial begin
        seg_tbl[0]  = 7'b1000000; seg_tbl[1]  = 7'b1111001;
        seg_tbl[2]  = 7'b0100100; seg_tbl[3]  = 7'b0110000;
        seg_tbl[4]  = 7'b0011001; seg_tbl[5]  = 7'b0010010;
        seg_tbl[6]  = 7'b0000010; seg_tbl[7]  = 7'b1111000;
        seg_tbl[8]  = 7'b0000000; seg_tbl[9]  = 7'b0010000;
        seg_tbl[10] = 7'b0001000; seg_tbl[11] = 7'b0000011;
        seg_tbl[12] = 7'b1000110; seg_tbl[13] = 7'b0100001;
        seg_tbl[14] = 7'b0000110; seg_tbl[15] = 7'b0001110;
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s txn %0d: got %0h expected %0h", nm, n_txn, act, expv);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int c);
        logic [3:0] t, u;
        t = 4'(c / 10);
        u = 4'(c % 10);
        return {t, u};
    endfunction

    task automatic step(input logic zv, input logic cv, input logic rv,
                        input logic mp, input logic [7:0] bcd, input logic ov,
                        input logic [3:0] rl, input logic [3:0] mr);
        exp_t e;
        @(negedge clk);
        z     = zv;
        clr   = cv;
        reset = rv;
        e.mp  = mp;
        e.bcd = bcd;
        e.ov  = ov;
        e.rl  = rl;
        e.mr  = mr;
        exp_q.push_back(e);
    endtask

    // Monitor: compare after every edge for which an expectation was queued.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_txn++;
                $display("txn %0d: pulse=%0b count=%02h ovf=%0b run=%0d max=%0d",
                         n_txn, match_pulse, bcd_count, ovf, run_len, max_run);
                chk("match_pulse", {7'd0, match_pulse}, {7'd0, e.mp});
                chk("bcd_count", bcd_count, e.bcd);
                chk("ovf", {7'd0, ovf}, {7'd0, e.ov});
                chk("run_len", {4'd0, run_len}, {4'd0, e.rl});
                chk("max_run", {4'd0, max_run}, {4'd0, e.mr});
                chk("hex0", {1'b0, hex0}, {1'b0, seg_tbl[e.bcd[3:0]]});
                chk("hex1", {1'b0, hex1}, {1'b0, seg_tbl[e.bcd[7:4]]});
                chk("hex2", {1'b0, hex2}, {1'b0, seg_tbl[e.mr]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held with z high, then release: first sample counts as a rise.
        step(1, 0, 1, 0, 8'h00, 0, 0, 0);
        step(1, 0, 1, 0, 8'h00, 0, 0, 0);
        step(1, 0, 0, 1, 8'h01, 0, 1, 1);
        step(0, 0, 0, 0, 8'h01, 0, 0, 1);

        // Runs and pulses: z = 0,1,1,1,0,1,0 after a clear.
        step(0, 1, 0, 0, 8'h00, 0, 0, 0);
        step(0, 0, 0, 0, 8'h00, 0, 0, 0);
        step(1, 0, 0, 1, 8'h01, 0, 1, 1);
        step(1, 0, 0, 0, 8'h01, 0, 2, 2);
        step(1, 0, 0, 0, 8'h01, 0, 3, 3);
        step(0, 0, 0, 0, 8'h01, 0, 0, 3);
        step(1, 0, 0, 1, 8'h02, 0, 1, 3);
        step(0, 0, 0, 0, 8'h02, 0, 0, 3);

        // Wrap and overflow: 105 separated pulses.
        step(0, 1, 0, 0, 8'h00, 0, 0, 0);
        for (int i = 1; i <= 105; i++) begin
            step(1, 0, 0, 1, to_bcd(i % 100), (i >= 100), 1, 1);
            step(0, 0, 0, 0, to_bcd(i % 100), (i >= 100), 0, 1);
        end

        // Run saturation: 20 cycles high from count 05, ovf still set.
        for (int k = 1; k <= 20; k++) begin
            step(1, 0, 0, (k == 1), 8'h06, 1, 4'((k > 15) ? 15 : k), 4'((k > 15) ? 15 : k));
        end
        step(0, 0, 0, 0, 8'h06, 1, 0, 15);

        // Clear on the same edge as a rise, then z stays high.
        step(1, 1, 0, 0, 8'h00, 0, 0, 0);
        step(1, 0, 0, 0, 8'h00, 0, 1, 1);
        step(1, 0, 0, 0, 8'h00, 0, 2, 2);
        step(1, 0, 0, 0, 8'h00, 0, 3, 3);
        step(0, 0, 0, 0, 8'h00, 0, 0, 3);

        // Reset mid-run at count 37 with z high.
        step(0, 1, 0, 0, 8'h00, 0, 0, 0);
        for (int i = 1; i <= 36; i++) begin
            step(1, 0, 0, 1, to_bcd(i), 0, 1, 1);
            step(0, 0, 0, 0, to_bcd(i), 0, 0, 1);
        end
        step(1, 0, 0, 1, 8'h37, 0, 1, 1);
        step(1, 0, 1, 0, 8'h00, 0, 0, 0);
        step(1, 0, 0, 1, 8'h01, 0, 1, 1);
        step(0, 0, 0, 0, 8'h01, 0, 0, 1);

        @(posedge clk);
        #2;
        chk("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/z_match_monitor.md
# z_match_monitor

Downstream consumer of the sequence-detector FSM's `z` output. It counts detected matches as rising edges of `z` in a two-digit BCD counter and tracks the current and longest run of consecutive `z`-high cycles. It drives three active-low 7-segment digits for the board display. All state is registered on one clock; the segment decode is combinational from registers.

## Interface
- No parameters; the counter width is fixed at two BCD digits and the run length at 4 bits.
- `clk`  in  1  system clock; the same clock as the detector FSM.
- `reset`  in  1  synchronous, active-high reset; sampled on the `clk` rising edge.
- `z`  in  1  detector output; treated as synchronous to `clk`.
- `clr`  in  1  synchronous clear of the statistics; lower priority than `reset`.
- `match_pulse`  out  1  one-cycle, registered pulse per rising edge of `z`.
- `bcd_count`  out  8  match count: [7:4] tens, [3:0] units; each nibble is 0–9.
- `ovf`  out  1  sticky flag, set when the count wraps from 99 to 00.
- `run_len`  out  4  consecutive `z`-high samples in the current run; saturates at 15.
- `max_run`  out  4  largest `run_len` reached since reset or clear.
- `hex0`  out  7  active-low segments {g,f,e,d,c,b,a} showing the units digit.
- `hex1`  out  7  active-low segments showing the tens digit.
- `hex2`  out  7  active-low segments showing `max_run` as hex 0–F.

## Operation
- Internal register `z_d` holds the `z` value sampled at the previous edge.
- `rise` is `z & ~z_d`, evaluated on the current sample.
- Update priority at each edge: `reset` > `clr` > normal.
- **Reset.** `z_d`, `match_pulse`, `bcd_count`, `ovf`, `run_len` and `max_run` all go to 0.
  - `hex0` and `hex1` then show "0" (7'b1000000); `hex2` shows "0".
- **Clear (`clr`=1, `reset`=0).**
  - `bcd_count`, `ovf`, `run_len`, `max_run` and `match_pulse` go to 0.
  - `z_d` still loads `z`, so a `z` held high through the clear is not counted as a new match afterwards.
- **Normal operation.**
  - `z_d` <= `z`.
  - `match_pulse` <= `rise`.
  - On `rise`, increment the units digit. When units is 9, units goes to 0 and tens increments.
  - When the count is 99, it becomes 00 and `ovf` is set to 1. `ovf` stays set until `reset` or `clr`.
  - If `z`=1: `run_len` <= min(`run_len`+1, 15). If `z`=0: `run_len` <= 0.
  - If `z`=1 and the new `run_len` exceeds `max_run`, `max_run` takes the new value, so `max_run` is never less than `run_len`.
- A BCD nibble never takes a value of 10–15 after reset.
  - If such a value is forced, the decoder blanks the digit (all segments 1).
- The segment decoder is a standard hex pattern (0–9, A, b, C, d, E, F) in active-low form.

## Timing
- All outputs except the `hex*` digits are registered.
- The `hex*` digits are combinational from registers and have no path from `z`, `clr` or `reset`.
- `z` sampled at edge k appears on `match_pulse`, `bcd_count`, `run_len` and `max_run` after edge k (latency 1 cycle).
- A `z` pulse one cycle wide gives exactly one `match_pulse`, one count increment and `run_len`=1 for one cycle.
- Back-to-back pattern 1,0,1 on `z` gives two rises, two pulses and two increments.
- The first sample after reset with `z`=1 counts as a rise, because `z_d` resets to 0.
- `clr` and `rise` in the same cycle: the clear wins, the rise is not counted, and `match_pulse`=0.
- `reset` asserted mid-run: all state returns to 0 at that edge. A `z` still high after reset release counts as a new rise.
- A rise that wraps 99→00 sets `ovf` and pulses `match_pulse` after the same edge.

## Test plan
- **Reset values.** Hold `reset` for 2 cycles with `z`=1 → all registered outputs are 0 and `hex0`/`hex1`/`hex2`=7'b1000000. Release `reset` → after the first edge, `bcd_count`=8'h01, `match_pulse`=1, `run_len`=1.
- **Runs and pulses.** `z` pattern 0,1,1,1,0,1,0 → `match_pulse` high after edges 2 and 6 only. `run_len` sequence is 0,1,2,3,0,1,0. `max_run` ends at 3. `bcd_count`=8'h02.
- **Wrap and overflow.** 100 separated `z` pulses → `bcd_count` steps through 8'h09→8'h10 and 8'h99→8'h00. `ovf`=1 after the 100th pulse and stays 1 after 5 more pulses (count 8'h05).
- **Run saturation.** Hold `z`=1 for 20 cycles → `run_len` and `max_run` saturate at 15, `hex2`=7'b0001110 ("F"), and `bcd_count` increases by 1 only.
- **Clear precedence.** Assert `clr` on the same edge as a rise, then keep `z` high for 3 cycles → count stays 8'h00, no `match_pulse`, `run_len` after the subsequent 3 edges reads 1,2,3, and `ovf`=0.
- **Reset mid-run.** With count 8'h37 and `z` high, assert `reset` for 1 cycle and keep `z` high → all outputs are 0 after the reset edge. On the next edge, `bcd_count`=8'h01 and `match_pulse`=1.
